// File: rtl/clock_divider_multi.sv
// clock_divider_multi
//
// CHANNELS independent programmable clock dividers that all run from clock_in.
// Each channel divides by N = P+1 cycles. Within each period it drives
// clock_out high for H cycles and then low for the remaining N-H cycles. The
// tick output pulses for one cycle on the first cycle of every period.
//
// Settings are written through one shared port into per-channel shadow
// registers. A channel copies its shadow values into its active registers only
// at a period boundary (start or wrap). A write therefore never shortens or
// stretches the period that is already running.
//
// Ports:
//   clock_in    source clock; all logic uses its rising edge
//   reset_n     asynchronous, active-low reset
//   enable      per-channel run enable (bit i -> channel i)
//   cfg_we      configuration write strobe
//   cfg_sel     channel index for the write; indices >= CHANNELS are ignored
//   cfg_period  period value P (the channel divides by P+1)
//   cfg_high    high time H in cycles per period
//   clock_out   divided clock per channel, registered
//   tick        one-cycle strobe at phase 0 of each period, registered
//
// Configuration port: a write is a single-cycle strobe. Every rising edge that
// samples cfg_we=1 with cfg_sel < CHANNELS commits cfg_period/cfg_high to that
// channel's shadow registers. There is no back-pressure.
//
// Per-channel state is kept in state_q (CH_IDLE / CH_RUN). It is visible by
// hierarchical reference together with phase_q and the active/shadow values.

module clock_divider_multi #(
    parameter int CHANNELS     = 4,
    parameter int WIDTH        = 16,
    parameter int SEL_W        = 2,
    parameter int RESET_PERIOD = 1,
    parameter int RESET_HIGH   = 1
) (
    input  logic                clock_in,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] enable,
    input  logic                cfg_we,
    input  logic [SEL_W-1:0]    cfg_sel,
    input  logic [WIDTH-1:0]    cfg_period,
    input  logic [WIDTH-1:0]    cfg_high,
    output logic [CHANNELS-1:0] clock_out,
    output logic [CHANNELS-1:0] tick
);

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_RUN  = 1'b1
    } ch_state_t;

    ch_state_t        state_q   [CHANNELS];
    ch_state_t        state_d   [CHANNELS];
    logic [WIDTH-1:0] phase_q   [CHANNELS];
    logic [WIDTH-1:0] phase_d   [CHANNELS];
    logic [WIDTH-1:0] p_act_q   [CHANNELS];
    logic [WIDTH-1:0] p_act_d   [CHANNELS];
    logic [WIDTH-1:0] h_act_q   [CHANNELS];
    logic [WIDTH-1:0] h_act_d   [CHANNELS];
    logic [WIDTH-1:0] p_sh_q    [CHANNELS];
    logic [WIDTH-1:0] p_sh_d    [CHANNELS];
    logic [WIDTH-1:0] h_sh_q    [CHANNELS];
    logic [WIDTH-1:0] h_sh_d    [CHANNELS];
    logic [CHANNELS-1:0] clock_d;
    logic [CHANNELS-1:0] tick_d;
    logic                sel_valid;

    always_comb begin
        sel_valid = 32'(cfg_sel) < 32'(CHANNELS);
        clock_d   = '0;
        tick_d    = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            state_d[i] = state_q[i];
            phase_d[i] = phase_q[i];
            p_act_d[i] = p_act_q[i];
            h_act_d[i] = h_act_q[i];
            p_sh_d[i]  = p_sh_q[i];
            h_sh_d[i]  = h_sh_q[i];

            if (cfg_we && sel_valid && (32'(cfg_sel) == 32'(i))) begin
                p_sh_d[i] = cfg_period;
                h_sh_d[i] = cfg_high;
            end

            if (!enable[i]) begin
                // Dropping enable stops the channel at once, even mid-period.
                state_d[i] = CH_IDLE;
                phase_d[i] = '0;
            end else if (state_q[i] == CH_IDLE || phase_q[i] == p_act_q[i]) begin
                // Period boundary: load the pre-edge shadow values. A write on
                // this same edge lands in the shadow and waits for the next
                // boundary.
                state_d[i] = CH_RUN;
                phase_d[i] = '0;
                p_act_d[i] = p_sh_q[i];
                h_act_d[i] = h_sh_q[i];
                tick_d[i]  = 1'b1;
                clock_d[i] = (h_sh_q[i] != '0);
            end else begin
                // phase_q < p_act_q here, so the increment cannot overflow.
                phase_d[i] = phase_q[i] + 1'b1;
                clock_d[i] = (phase_d[i] < h_act_q[i]);
            end
        end
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= CH_IDLE;
                phase_q[i] <= '0;
                p_act_q[i] <= WIDTH'(RESET_PERIOD);
                h_act_q[i] <= WIDTH'(RESET_HIGH);
                p_sh_q[i]  <= WIDTH'(RESET_PERIOD);
                h_sh_q[i]  <= WIDTH'(RESET_HIGH);
            end
            clock_out <= '0;
            tick      <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= state_d[i];
                phase_q[i] <= phase_d[i];
                p_act_q[i] <= p_act_d[i];
                h_act_q[i] <= h_act_d[i];
                p_sh_q[i]  <= p_sh_d[i];
                h_sh_q[i]  <= h_sh_d[i];
            end
            clock_out <= clock_d;
            tick      <= tick_d;
        end
    end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Testbench for clock_divider_multi (3 channels, 8-bit period/high).
// Reference model: each channel is tracked as "cycles into the current period"
// against an integer period length N = P+1 and high time H. Every edge it
// reports high = (t < H) and tick = (t == 0).

module tb_clock_divider_multi;

    localparam int CH = 3;
    localparam int W  = 8;
    localparam int SW = 2;

    // ---------------- clock / reset / DUT ----------------
    logic          clock_in   = 1'b0;
    logic          reset_n    = 1'b1;
    logic [CH-1:0] enable     = '0;
    logic          cfg_we     = 1'b0;
    logic [SW-1:0] cfg_sel    = '0;
    logic [W-1:0]  cfg_period = '0;
    logic [W-1:0]  cfg_high   = '0;
    logic [CH-1:0] clock_out;
    logic [CH-1:0] tick;

    always #5 clock_in = ~clock_in;

    clock_divider_multi #(
        .CHANNELS(CH), .WIDTH(W), .SEL_W(SW), .RESET_PERIOD(1), .RESET_HIGH(1)
    ) dut (
        .clock_in(clock_in), .reset_n(reset_n), .enable(enable),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_period(cfg_period),
        .cfg_high(cfg_high), .clock_out(clock_out), .tick(tick)
    );

    // ---------------- scoreboard ----------------
    int vec_count  = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_count++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int            sh_p [CH];
    int            sh_h [CH];
    int            m_t  [CH];
    int            m_n  [CH];
    int            m_h  [CH];
    bit            m_run[CH];
    logic [CH-1:0] m_clk;
    logic [CH-1:0] m_tick;

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            sh_p[i] = 1; sh_h[i] = 1;
            m_t[i] = 0; m_n[i] = 2; m_h[i] = 1; m_run[i] = 0;
        end
        m_clk = '0; m_tick = '0;
    endtask

    // One rising edge: update the model from the inputs held across the edge,
    // then compare the registered outputs 1 time unit later.
    task automatic step();
        @(posedge clock_in);
        for (int i = 0; i < CH; i++) begin
            if (!enable[i]) begin
                m_run[i] = 0; m_t[i] = 0;
                m_clk[i] = 1'b0; m_tick[i] = 1'b0;
            end else begin
                if (!m_run[i] || (m_t[i] + 1 == m_n[i])) begin
                    m_run[i] = 1; m_t[i] = 0;
                    m_n[i] = sh_p[i] + 1; m_h[i] = sh_h[i];
                end else begin
                    m_t[i]++;
                end
                m_clk[i]  = (m_t[i] < m_h[i]);
                m_tick[i] = (m_t[i] == 0);
            end
        end
        if (cfg_we && int'(cfg_sel) < CH) begin
            sh_p[int'(cfg_sel)] = int'(cfg_period);
            sh_h[int'(cfg_sel)] = int'(cfg_high);
        end
        #1;
        check("model_clock_out", 32'(clock_out), 32'(m_clk));
        check("model_tick", 32'(tick), 32'(m_tick));
    endtask

    // ---------------- driver ----------------
    task automatic cfg_write(input int sel, input int p, input int h);
        cfg_we = 1'b1; cfg_sel = SW'(sel); cfg_period = W'(p); cfg_high = W'(h);
        step();
        cfg_we = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [CH-1:0] en;
        logic          we;
        logic [SW-1:0] sel;
        logic [W-1:0]  p;
        logic [W-1:0]  h;
        logic [CH-1:0] exp_clk;
        logic [CH-1:0] exp_tick;
    } vec_t;

    vec_t vecs[16];

    initial begin
        int found;
        int nt;
        int nh;
        logic [9:0] exp_c;
        logic [9:0] exp_t;

        // ch0 default toggle; ch1 P=5/H=3 (D=2 toggle equivalent); ch1 drop
        // and re-enable mid-high; ignored write with cfg_sel=3.
        vecs[0]  = '{3'b001, 1'b0, 2'd0, 8'd0, 8'd0, 3'b001, 3'b001};
        vecs[1]  = '{3'b001, 1'b0, 2'd0, 8'd0, 8'd0, 3'b000, 3'b000};
        vecs[2]  = '{3'b001, 1'b0, 2'd0, 8'd0, 8'd0, 3'b001, 3'b001};
        vecs[3]  = '{3'b001, 1'b1, 2'd1, 8'd5, 8'd3, 3'b000, 3'b000};
        vecs[4]  = '{3'b011, 1'b0, 2'd0, 8'd0, 8'd0, 3'b011, 3'b011};
        vecs[5]  = '{3'b011, 1'b0, 2'd0, 8'd0, 8'd0, 3'b010, 3'b000};
        vecs[6]  = '{3'b011, 1'b0, 2'd0, 8'd0, 8'd0, 3'b011, 3'b001};
        vecs[7]  = '{3'b011, 1'b0, 2'd0, 8'd0, 8'd0, 3'b000, 3'b000};
        vecs[8]  = '{3'b011, 1'b0, 2'd0, 8'd0, 8'd0, 3'b001, 3'b001};
        vecs[9]  = '{3'b011, 1'b0, 2'd0, 8'd0, 8'd0, 3'b000, 3'b000};
        vecs[10] = '{3'b011, 1'b0, 2'd0, 8'd0, 8'd0, 3'b011, 3'b011};
        vecs[11] = '{3'b001, 1'b0, 2'd0, 8'd0, 8'd0, 3'b000, 3'b000};
        vecs[12] = '{3'b011, 1'b0, 2'd0, 8'd0, 8'd0, 3'b011, 3'b011};
        vecs[13] = '{3'b011, 1'b1, 2'd3, 8'd0, 8'd0, 3'b010, 3'b000};
        vecs[14] = '{3'b011, 1'b0, 2'd0, 8'd0, 8'd0, 3'b011, 3'b001};
        vecs[15] = '{3'b011, 1'b0, 2'd0, 8'd0, 8'd0, 3'b000, 3'b000};

        // ---- reset ----
        model_reset();
        #2 reset_n = 1'b0;
        #1;
        check("reset_clock_out", 32'(clock_out), 32'd0);
        check("reset_tick", 32'(tick), 32'd0);
        @(negedge clock_in);
        reset_n = 1'b1;

        // ---- table ----
        for (int k = 0; k < 16; k++) begin
            enable = vecs[k].en; cfg_we = vecs[k].we; cfg_sel = vecs[k].sel;
            cfg_period = vecs[k].p; cfg_high = vecs[k].h;
            step();
            check("table_clock_out", 32'(clock_out), 32'(vecs[k].exp_clk));
            check("table_tick", 32'(tick), 32'(vecs[k].exp_tick));
        end
        cfg_we = 1'b0;

        // ---- ch0 P=7/H=4, rewritten to P=3/H=2 mid-period ----
        cfg_write(0, 7, 4);
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            step();
            if (m_tick[0] && m_n[0] == 8) found = 1;
        end
        check("sync_p7_reached", 32'(found), 32'd1);
        step();
        step();
        exp_c = 10'b1001100001;
        exp_t = 10'b1000100000;
        cfg_write(0, 3, 2);
        check("midwrite_clk", 32'(clock_out[0]), 32'(exp_c[0]));
        check("midwrite_tick", 32'(tick[0]), 32'(exp_t[0]));
        for (int k = 1; k < 10; k++) begin
            step();
            check("midwrite_clk", 32'(clock_out[0]), 32'(exp_c[k]));
            check("midwrite_tick", 32'(tick[0]), 32'(exp_t[k]));
        end

        // ---- write landing exactly on the wrap edge ----
        found = 0;
        for (int k = 0; k < 10 && found == 0; k++) begin
            if (m_t[0] == 3) found = 1;
            else step();
        end
        check("sync_wrap_reached", 32'(found), 32'd1);
        exp_c = 10'b0000010011;
        exp_t = 10'b0000010001;
        cfg_write(0, 5, 1);
        check("wrapwrite_clk", 32'(clock_out[0]), 32'(exp_c[0]));
        check("wrapwrite_tick", 32'(tick[0]), 32'(exp_t[0]));
        for (int k = 1; k < 10; k++) begin
            step();
            check("wrapwrite_clk", 32'(clock_out[0]), 32'(exp_c[k]));
            check("wrapwrite_tick", 32'(tick[0]), 32'(exp_t[k]));
        end

        // ---- ch2 boundaries ----
        cfg_write(2, 4, 0);
        enable[2] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            check("h0_const_low", 32'(clock_out[2]), 32'd0);
        end
        cfg_write(2, 4, 7);
        for (int k = 0; k < 6; k++) step();
        nt = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            check("hbig_const_high", 32'(clock_out[2]), 32'd1);
            nt += int'(tick[2]);
        end
        check("hbig_tick_count", 32'(nt), 32'd2);
        cfg_write(2, 0, 1);
        for (int k = 0; k < 6; k++) step();
        for (int k = 0; k < 5; k++) begin
            step();
            check("p0_clk_high", 32'(clock_out[2]), 32'd1);
            check("p0_tick_high", 32'(tick[2]), 32'd1);
        end

        // ---- ch1 maximum period P=255, H=128 ----
        cfg_write(1, 255, 128);
        found = 0;
        for (int k = 0; k < 300 && found == 0; k++) begin
            step();
            if (m_tick[1] && m_n[1] == 256) found = 1;
        end
        check("sync_pmax_reached", 32'(found), 32'd1);
        nt = 0; nh = 0;
        for (int k = 0; k < 512; k++) begin
            step();
            nt += int'(tick[1]);
            nh += int'(clock_out[1]);
        end
        check("pmax_tick_count", 32'(nt), 32'd2);
        check("pmax_high_count", 32'(nh), 32'd256);

        // ---- randomized traffic ----
        for (int k = 0; k < 1500; k++) begin
            int p;
            int r;
            for (int i = 0; i < CH; i++)
                if ($urandom_range(0, 63) == 0) enable[i] = ~enable[i];
            cfg_we = ($urandom_range(0, 7) == 0);
            cfg_sel = SW'($urandom_range(0, 3));
            r = $urandom_range(0, 9);
            p = (r == 0) ? 0 : (r == 1) ? 255 : $urandom_range(1, 12);
            cfg_period = W'(p);
            cfg_high = W'($urandom_range(0, (p + 2 > 255) ? 255 : p + 2));
            step();
        end
        cfg_we = 1'b0;

        // ---- asynchronous reset between edges, mid-period ----
        enable = 3'b111;
        cfg_write(0, 7, 4);
        for (int k = 0; k < 13; k++) step();
        #3 reset_n = 1'b0;
        #1;
        check("async_reset_clock_out", 32'(clock_out), 32'd0);
        check("async_reset_tick", 32'(tick), 32'd0);
        @(posedge clock_in);
        @(negedge clock_in);
        check("held_reset_clock_out", 32'(clock_out), 32'd0);
        enable = 3'b001;
        model_reset();
        reset_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            check("post_reset_default", 32'(clock_out), (k % 2 == 0) ? 32'd1 : 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule

// File: doc/clock_divider_multi.md
Name: clock_divider_multi

Overview:
- CHANNELS independent programmable clock dividers sharing one source clock_in.
- Each channel has a runtime-configurable period and high time (arbitrary duty), a per-channel enable, and a one-cycle tick strobe marking each period start.
- Configuration goes through a shared write port into per-channel shadow registers. New settings take effect only at a period boundary, so outputs never glitch or produce runt pulses.
- Serves as the clock/strobe generator for display scan, debouncers and slow peripheral timing.

Parameters:
- CHANNELS, 4, number of independent divider channels (1..16).
- WIDTH, 16, bit width of period/high registers and phase counter.
- SEL_W, 2, width of cfg_sel; must be at least clog2(CHANNELS), and at least 1.
- RESET_PERIOD, 1, reset value of every channel's shadow period (P).
- RESET_HIGH, 1, reset value of every channel's shadow high time (H).

Ports:
- clock_in  input  1  source clock; all logic on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- enable  input  CHANNELS  per-channel run enable, bit i for channel i.
- cfg_we  input  1  configuration write strobe, sampled each rising edge.
- cfg_sel  input  SEL_W  channel index for the write.
- cfg_period  input  WIDTH  period value P; channel period is N = P+1 cycles.
- cfg_high  input  WIDTH  high time H, in cycles per period.
- clock_out  output  CHANNELS  divided clock per channel, registered.
- tick  output  CHANNELS  one-cycle pulse at phase 0 of each period, registered.

Behaviour:

Reset (asynchronous, immediate, also mid-period):
- clock_out=0, tick=0, all channels idle.
- Shadow P=RESET_PERIOD, shadow H=RESET_HIGH.
- Active P/H = shadow values.

Per-channel state:
- running flag, phase counter (WIDTH bits), active P, active H.
- All comparisons are unsigned. The phase counter never exceeds the active P; no modular wrap other than the defined wrap to 0.

Idle:
- Entered when enable[i] is sampled 0, at any point, including mid-period.
- Next edge: running=0, phase=0, clock_out[i]=0, tick[i]=0.
- Active values are not changed while idle.

Start:
- First edge with enable[i]=1 while idle: running=1, phase=0, active P/H loaded from shadow (pre-edge value).
- tick[i]=1 and clock_out[i]=(0 < H_new) on that same edge.

Running, each edge:
- If phase==P_act: phase=0, reload active P/H from shadow, tick=1.
- Otherwise: phase=phase+1, tick=0.
- clock_out[i] is registered = (new phase < new H_act).
- Net effect: each period is H cycles high followed by N-H cycles low, with tick coincident with the first cycle of the period.

Boundary cases:
- H=0: clock_out constant 0.
- H>=N: clock_out constant 1.
- P=0: N=1, tick held 1 every cycle, clock_out=(H>0).
- P=2^WIDTH-1: no overflow; phase wraps to 0 after reaching P.

Configuration writes:
- cfg_we=1 with cfg_sel<CHANNELS writes the shadow P/H of that channel only.
- cfg_sel>=CHANNELS: write ignored, no state change.
- A write never alters the active values mid-period.
- Write on the same edge as a wrap or start: the load uses the pre-write shadow; the new value applies at the following boundary.
- Back-to-back writes to one channel: the last write before a boundary wins.

Latency:
- Outputs change on the edge after enable/phase conditions are sampled.
- Channels are fully independent; simultaneous events on different channels do not interact.

Legacy toggle-divider equivalence:
- A toggle divider with count D corresponds to P=2D+1, H=D+1.

Test Plan:
- Reset, then enable[0]=1 with defaults P=1,H=1 -> clock_out[0] = 1,0,1,0..., tick[0] high on every high cycle; other channels remain 0.
- ch1 write P=9,H=3, then enable -> repeating 3 high / 7 low cycles, tick once per 10 cycles, on the first high cycle; P=5,H=3 matches a D=2 toggle divider (3 high / 3 low).
- ch2 boundaries: H=0 -> constant 0; P=4,H=7 -> constant 1 with tick every 5 cycles; P=0,H=1 -> clock_out and tick constant 1.
- ch0 running P=7,H=4; write P=3,H=2 at phase 2 -> current period completes as 4 high/4 low, then 2 high/2 low; a write landing exactly on the wrap edge applies one period later.
- Drop enable[1] mid-high-phase -> next edge clock_out[1]=0, tick=0; re-enable -> tick and fresh period starting at phase 0. Write with cfg_sel=3 while CHANNELS=3 -> no effect.
- Assert reset_n low between clock edges mid-period -> all outputs 0 immediately (before the next edge); shadows return to RESET_PERIOD/RESET_HIGH.
